// File: rtl/handshake_pulse_tx.sv
// Multi-channel pulse-to-4-phase-handshake source controller with per-channel
// pending-pulse queueing, saturating pending counters and sticky overflow flags.
module handshake_pulse_tx #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic [CHANNELS-1:0] ack_in,
    input  logic [CHANNELS-1:0] ovf_clr,
    output logic [CHANNELS-1:0] req_out,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   ack_s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   req_q, done_q, ovf_q;
        logic                   done_d, ovf_d, drop;

        // ack_in is asynchronous; only the last synchronizer stage is ever looked at.
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in[ch]};
            end
        end

        assign ack_s = sync_q[SYNC_STAGES-1];

        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            drop    = 1'b0;
            done_d  = 1'b0;

            if (state_q == ST_IDLE) begin
                // A pulse arriving with a queued launch replaces the consumed entry.
                if (cnt_q != '0) begin
                    state_d = ST_REQ;
                    if (!pulse_in[ch]) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (pulse_in[ch]) begin
                    state_d = ST_REQ;
                end
            end else if (pulse_in[ch]) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: ;
                ST_REQ: begin
                    if (ack_s) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Set beats clear when a drop and ovf_clr coincide.
            ovf_d = drop | (ovf_q & ~ovf_clr[ch]);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= (state_d == ST_REQ);
                done_q  <= done_d;
                ovf_q   <= ovf_d;
            end
        end

        assign req_out[ch] = req_q;
        assign done[ch]    = done_q;
        assign ovf[ch]     = ovf_q;
        assign busy[ch]    = (state_q != ST_IDLE) || (cnt_q != '0);
    end

endmodule

// File: tb/tb_handshake_pulse_tx.sv
// Self-checking bench for handshake_pulse_tx: a per-cycle vector table for the
// loopback handshake, then directed multi-cycle sequences with a receiver model.
module tb_handshake_pulse_tx;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] pulse_in;
    logic [CH-1:0] ack_in;
    logic [CH-1:0] ovf_clr;
    logic [CH-1:0] req_out;
    logic [CH-1:0] done;
    logic [CH-1:0] busy;
    logic [CH-1:0] ovf;

    int n_cmp = 0;
    int n_err = 0;

    int ack_delay[CH] = '{default: 0};
    int ack_wait[CH]  = '{default: 0};
    bit ack_hold[CH]  = '{default: 1'b0};
    int done_cnt[CH]  = '{default: 0};

    typedef struct {
        logic [CH-1:0] pulse;
        logic [CH-1:0] clr;
        logic [CH-1:0] exp_req;
        logic [CH-1:0] exp_done;
        logic [CH-1:0] exp_busy;
        logic [CH-1:0] exp_ovf;
    } vec_t;

    vec_t vecs[13];

    handshake_pulse_tx #(
        .CHANNELS   (CH),
        .SYNC_STAGES(2),
        .CNT_W      (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pulse_in(pulse_in),
        .ack_in  (ack_in),
        .ovf_clr (ovf_clr),
        .req_out (req_out),
        .done    (done),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Receiver: ack_in follows req_out after ack_delay cycles, or is held low.
    initial begin
        ack_in = '0;
        forever begin
            @(posedge clk);
            #3;
            for (int c = 0; c < CH; c++) begin
                if (ack_hold[c]) begin
                    ack_in[c]   = 1'b0;
                    ack_wait[c] = 0;
                end else if (ack_in[c] != req_out[c]) begin
                    if (ack_wait[c] >= ack_delay[c]) begin
                        ack_in[c]   = req_out[c];
                        ack_wait[c] = 0;
                    end else begin
                        ack_wait[c]++;
                    end
                end else begin
                    ack_wait[c] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < CH; c++) begin
                if (done[c] === 1'b1) done_cnt[c]++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_cycle(input logic [CH-1:0] mask);
        pulse_in = mask;
        tick();
        pulse_in = '0;
    endtask

    task automatic wait_done(input int c, input int target, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt[c] < target; i++) tick();
        check(name, 32'(done_cnt[c]), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int base[CH];
        int pulses[CH];
        int got;
        bit expect_launch;
        bit seen;
        bit seen_req;
        logic [CH-1:0] mask;

        // Row i is applied before, and checked after, edge i+1 following reset release.
        vecs[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{4'h9, 4'h0, 4'h9, 4'h0, 4'h9, 4'h0};
        vecs[5]  = '{4'h0, 4'h0, 4'h9, 4'h0, 4'h9, 4'h0};
        vecs[6]  = '{4'h0, 4'h0, 4'h9, 4'h0, 4'h9, 4'h0};
        vecs[7]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0};
        vecs[8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0};
        vecs[9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0};
        vecs[10] = '{4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0};
        vecs[11] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        reset_n  = 1'b0;
        pulse_in = '0;
        ovf_clr  = '0;
        #20;
        check("reset req_out", 32'(req_out), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset ovf", 32'(ovf), 32'h0);
        #2;
        reset_n = 1'b1;

        // Loopback handshake on ch0 and ch3, instantaneous receiver.
        for (int i = 0; i < 13; i++) begin
            pulse_in = vecs[i].pulse;
            ovf_clr  = vecs[i].clr;
            tick();
            check($sformatf("vec%0d req_out", i), 32'(req_out), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
        end
        pulse_in = '0;
        ovf_clr  = '0;

        // Queueing: three back-to-back pulses on ch1 with a slow receiver.
        ack_delay[1] = 20;
        got = 0;
        expect_launch = 1'b0;
        pulse_cycle(4'b0010);
        check("queue launch req", 32'(req_out[1]), 32'h1);
        pulse_cycle(4'b0010);
        pulse_cycle(4'b0010);
        check("queue busy", 32'(busy[1]), 32'h1);
        for (int i = 0; i < 400 && got < 3; i++) begin
            tick();
            if (expect_launch) begin
                check("queue relaunch after idle", 32'(req_out[1]), 32'h1);
                expect_launch = 1'b0;
            end
            if (done[1]) begin
                got++;
                check("queue idle gap req", 32'(req_out[1]), 32'h0);
                if (got < 3) expect_launch = 1'b1;
            end
        end
        check("queue done count", 32'(got), 32'd3);
        check("queue ovf", 32'(ovf[1]), 32'h0);
        base[1] = done_cnt[1];
        idle_cycles(40);
        check("queue no extra done", 32'(done_cnt[1]), 32'(base[1]));
        check("queue busy clear", 32'(busy[1]), 32'h0);

        // Overflow on ch2: receiver holds ack low, 1 in flight + 3 pending + 2 dropped.
        ack_hold[2] = 1'b1;
        base[2] = done_cnt[2];
        for (int i = 0; i < 4; i++) pulse_cycle(4'b0100);
        check("ovf not yet set", 32'(ovf[2]), 32'h0);
        check("ovf req in flight", 32'(req_out[2]), 32'h1);
        pulse_cycle(4'b0100);
        check("ovf set on drop", 32'(ovf[2]), 32'h1);
        idle_cycles(3);
        check("ovf sticky", 32'(ovf[2]), 32'h1);
        pulse_in = 4'b0100;
        ovf_clr  = 4'b0100;
        tick();
        pulse_in = '0;
        ovf_clr  = '0;
        check("ovf set beats clear", 32'(ovf[2]), 32'h1);
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = '0;
        check("ovf cleared", 32'(ovf[2]), 32'h0);
        ack_hold[2] = 1'b0;
        wait_done(2, base[2] + 4, 200, "ovf done count");
        idle_cycles(20);
        check("ovf no extra done", 32'(done_cnt[2]), 32'(base[2] + 4));
        check("ovf stays clear", 32'(ovf[2]), 32'h0);
        check("ovf busy clear", 32'(busy[2]), 32'h0);

        // Simultaneous launch and arrival on ch3 while cnt=2 in IDLE.
        ack_delay[3] = 2;
        base[3] = done_cnt[3];
        pulse_cycle(4'b1000);
        pulse_cycle(4'b1000);
        pulse_cycle(4'b1000);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done[3]) begin
                seen = 1'b1;
                break;
            end
        end
        check("simul first done seen", 32'(seen), 32'h1);
        pulse_cycle(4'b1000);
        check("simul relaunch", 32'(req_out[3]), 32'h1);
        wait_done(3, base[3] + 4, 300, "simul done count");
        idle_cycles(30);
        check("simul no extra done", 32'(done_cnt[3]), 32'(base[3] + 4));
        check("simul busy clear", 32'(busy[3]), 32'h0);

        // Reset mid-handshake on ch0: REQ with cnt=3 and ovf set.
        ack_hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) pulse_cycle(4'b0001);
        check("rst pre req", 32'(req_out[0]), 32'h1);
        check("rst pre ovf", 32'(ovf[0]), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst async req_out", 32'(req_out), 32'h0);
        check("rst async busy", 32'(busy), 32'h0);
        check("rst async ovf", 32'(ovf), 32'h0);
        #4;
        reset_n = 1'b1;
        ack_hold[0] = 1'b0;
        base[0] = done_cnt[0];
        seen_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen_req = seen_req | req_out[0];
        end
        check("rst no spurious req", 32'(seen_req), 32'h0);
        check("rst no spurious done", 32'(done_cnt[0]), 32'(base[0]));
        pulse_cycle(4'b0001);
        check("rst fresh launch", 32'(req_out[0]), 32'h1);
        wait_done(0, base[0] + 1, 50, "rst fresh done");

        // Independence: random traffic, pending kept within capacity so nothing drops.
        ack_delay[0] = 0;
        ack_delay[1] = 1;
        ack_delay[2] = 3;
        ack_delay[3] = 5;
        for (int c = 0; c < CH; c++) begin
            base[c]   = done_cnt[c];
            pulses[c] = 0;
        end
        for (int i = 0; i < 600; i++) begin
            mask = '0;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0 && (pulses[c] - (done_cnt[c] - base[c])) < 4) begin
                    mask[c] = 1'b1;
                    pulses[c]++;
                end
            end
            pulse_cycle(mask);
        end
        for (int c = 0; c < CH; c++) begin
            wait_done(c, base[c] + pulses[c], 500, $sformatf("indep ch%0d done", c));
            check($sformatf("indep ch%0d ovf", c), 32'(ovf[c]), 32'h0);
        end
        idle_cycles(5);
        check("indep busy clear", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
